// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   PC_W                 : default PC / target width (byte address, word aligned)
//   btb_idx_w / btb_tag_w: BTB index and tag widths for a given geometry
//   btb_entry_t          : one BTB entry {valid, tag, target, ctr}
//   CTR_*                : 2-bit saturating branch counter states
// Entry tag/target fields are sized by the package PC_W. Tags are stored
// zero-extended, so any instance PC_W must not exceed the package PC_W.
package fetch_pkg;

  localparam int PC_W = 12;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  function automatic int btb_idx_w(input int btb_n);
    return (btb_n <= 2) ? 1 : $clog2(btb_n);
  endfunction

  // Bits [1:0] are the byte offset and never take part in index or tag.
  function automatic int btb_tag_w(input int pc_w, input int btb_n);
    return pc_w - btb_idx_w(btb_n) - 2;
  endfunction

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] tag;
    logic [PC_W-1:0] target;
    logic [1:0]      ctr;
  } btb_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Handshake/bus bundle of the fetch stage.
//   go, redirect, redirect_pc           : PC control from the pipeline
//   upd_valid/pc/taken/target           : branch resolution from execute
//   imem_addr / imem_data               : asynchronous instruction ROM port
//   pc_4, instruction, addr, p          : values for the IF/ID register
// slave  = the fetch stage, master = its environment.
interface fetch_stage_if #(
  parameter int PC_W = 12
);
  logic            go;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic [PC_W-1:0] pc_4;
  logic [31:0]     instruction;
  logic [PC_W-1:0] addr;
  logic            p;

  modport master (
    output go, redirect, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output imem_data,
    input  imem_addr, pc_4, instruction, addr, p
  );

  modport slave (
    input  go, redirect, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  imem_data,
    output imem_addr, pc_4, instruction, addr, p
  );
endinterface

// File: rtl/fetch_stage_btb.sv
// Direct-mapped branch target buffer.
//   clk, rst                  : clock, asynchronous active-high reset
//   lookup_pc                 : fetch PC, looked up combinationally
//   pred_taken, pred_target   : prediction (target is 0 on a miss)
//   upd_valid/pc/taken/target : resolved branch, written on the rising edge
// A lookup and update on the same index in one cycle sees the old entry.
module btb #(
  parameter int PC_W  = fetch_pkg::PC_W,
  parameter int BTB_N = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);
  import fetch_pkg::*;

  localparam int IW = btb_idx_w(BTB_N);
  localparam int TW = btb_tag_w(PC_W, BTB_N);
  localparam int EW = fetch_pkg::PC_W;

  localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

  logic [IW-1:0] lk_idx, up_idx;
  logic [TW-1:0] lk_tag, up_tag;
  logic [PC_W-1:0] up_target_al;
  logic unused_bits;

  btb_entry_t entries [BTB_N];
  btb_entry_t lk_ent, up_ent, up_next;
  logic lk_hit, up_hit, up_write;

  assign lk_idx = lookup_pc[IW+1:2];
  assign lk_tag = lookup_pc[PC_W-1:IW+2];
  assign up_idx = upd_pc[IW+1:2];
  assign up_tag = upd_pc[PC_W-1:IW+2];
  assign up_target_al = {upd_target[PC_W-1:2], 2'b00};
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Lookup port
  assign lk_ent      = entries[lk_idx];
  assign lk_hit      = lk_ent.valid && (lk_ent.tag == EW'(lk_tag));
  assign pred_taken  = lk_hit && lk_ent.ctr[1];
  assign pred_target = lk_hit ? lk_ent.target[PC_W-1:0] : '0;

  // Update port: compute the new contents of the addressed entry once
  assign up_ent = entries[up_idx];
  assign up_hit = up_ent.valid && (up_ent.tag == EW'(up_tag));

  always_comb begin
    up_next  = up_ent;
    up_write = 1'b0;
    if (upd_valid) begin
      if (up_hit) begin
        up_write = 1'b1;
        if (upd_taken) begin
          up_next.ctr    = (up_ent.ctr == CTR_ST) ? CTR_ST : up_ent.ctr + 2'd1;
          up_next.target = EW'(up_target_al);
        end else begin
          up_next.ctr    = (up_ent.ctr == CTR_SNT) ? CTR_SNT : up_ent.ctr - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate, evicting whatever branch occupied this slot
        up_write = 1'b1;
        up_next  = '{valid: 1'b1, tag: EW'(up_tag), target: EW'(up_target_al), ctr: CTR_WT};
      end
    end
  end

  generate
    for (genvar gi = 0; gi < BTB_N; gi++) begin : g_entry
      btb_entry_t entry_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= RESET_ENTRY;
        end else if (up_write && (up_idx == IW'(gi))) begin
          entry_reg <= up_next;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, PC+4 adder and BTB.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_stage_if.slave (control, BTB update, imem, IF/ID values)
// All outputs are combinational from the PC and BTB state.
module fetch_stage #(
  parameter int              PC_W     = fetch_pkg::PC_W,
  parameter int              BTB_N    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_stage_if.slave bus
);
  import fetch_pkg::*;

  localparam logic [PC_W-1:0] RESET_PC_AL = {RESET_PC[PC_W-1:2], 2'b00};
  localparam logic [PC_W-1:0] PC_STEP     = PC_W'(4);

  logic [PC_W-1:0] pc_reg, pc_next, pc_plus4;
  logic [PC_W-1:0] redirect_al;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            unused_bits;

  assign redirect_al = {bus.redirect_pc[PC_W-1:2], 2'b00};
  assign unused_bits = ^bus.redirect_pc[1:0];
  assign pc_plus4    = pc_reg + PC_STEP;  // wraps modulo 2^PC_W

  btb #(
    .PC_W  (PC_W),
    .BTB_N (BTB_N)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (pc_reg),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (bus.upd_valid),
    .upd_pc      (bus.upd_pc),
    .upd_taken   (bus.upd_taken),
    .upd_target  (bus.upd_target)
  );

  // A redirect wins even over a stall: the wrong-path PC must never survive.
  always_comb begin
    pc_next = pc_reg;
    if (bus.redirect)     pc_next = redirect_al;
    else if (!bus.go)     pc_next = pc_reg;
    else if (pred_taken)  pc_next = pred_target;
    else                  pc_next = pc_plus4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_reg <= RESET_PC_AL;
    else     pc_reg <= pc_next;
  end

  assign bus.imem_addr   = pc_reg;
  assign bus.pc_4        = pc_plus4;
  assign bus.instruction = bus.imem_data;
  assign bus.addr        = pred_target;
  assign bus.p           = pred_taken;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  fetch_stage_if #(.PC_W(12)) bus ();

  fetch_stage #(.PC_W(12), .BTB_N(8), .RESET_PC(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction ROM model: word derived from its address
  assign bus.imem_data = 32'hC0DE_0000 | {20'd0, bus.imem_addr};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Jump the PC to a new address with go held low
  task automatic jump(input logic [11:0] a);
    bus.go = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = a;
    step();
    bus.redirect = 1'b0;
  endtask

  task automatic update(input logic [11:0] pc, input logic taken, input logic [11:0] tgt);
    bus.upd_valid = 1'b1;
    bus.upd_pc = pc;
    bus.upd_taken = taken;
    bus.upd_target = tgt;
    step();
    bus.upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.go = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;
    rst = 1'b1;
    repeat (2) step();
    tests++; if (bus.imem_addr !== 12'h000) begin fails++; $display("FAIL reset_pc got %h want 000", bus.imem_addr); end
    tests++; if (bus.pc_4 !== 12'h004) begin fails++; $display("FAIL reset_pc4 got %h want 004", bus.pc_4); end
    tests++; if (bus.p !== 1'b0 || bus.addr !== 12'h000) begin fails++; $display("FAIL reset_pred got p=%b addr=%h want 0/000", bus.p, bus.addr); end
    rst = 1'b0;
    $display("[TB] reset: pc=%h pc_4=%h p=%b", bus.imem_addr, bus.pc_4, bus.p);
  endtask

  task automatic test_sequential();
    logic [11:0] exp_pc [3];
    exp_pc[0] = 12'h000; exp_pc[1] = 12'h004; exp_pc[2] = 12'h008;
    bus.go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.imem_addr !== exp_pc[i]) begin fails++; $display("FAIL seq_pc%0d got %h want %h", i, bus.imem_addr, exp_pc[i]); end
      tests++; if (bus.p !== 1'b0 || bus.addr !== 12'h000) begin fails++; $display("FAIL seq_pred%0d got p=%b addr=%h want 0/000", i, bus.p, bus.addr); end
      tests++; if (bus.instruction !== (32'hC0DE_0000 | {20'd0, exp_pc[i]})) begin fails++; $display("FAIL seq_instr%0d got %h want %h", i, bus.instruction, 32'hC0DE_0000 | {20'd0, exp_pc[i]}); end
      $display("[TB] seq: pc=%h instr=%h", bus.imem_addr, bus.instruction);
      if (i < 2) step();
    end
  endtask

  task automatic test_btb_alloc();
    bus.go = 1'b0;
    update(12'h010, 1'b1, 12'h100);
    jump(12'h010);
    tests++; if (bus.p !== 1'b1 || bus.addr !== 12'h100) begin fails++; $display("FAIL alloc_pred got p=%b addr=%h want 1/100", bus.p, bus.addr); end
    bus.go = 1'b1;
    step();
    tests++; if (bus.imem_addr !== 12'h100) begin fails++; $display("FAIL alloc_follow got %h want 100", bus.imem_addr); end
    $display("[TB] alloc: followed prediction to %h", bus.imem_addr);
  endtask

  task automatic test_counter_decay();
    bus.go = 1'b0;
    // ctr 2 -> 1 -> 0 -> 0 (would wrap to 3 without saturation)
    for (int i = 0; i < 3; i++) update(12'h010, 1'b0, 12'h000);
    jump(12'h010);
    tests++; if (bus.p !== 1'b0 || bus.addr !== 12'h100) begin fails++; $display("FAIL decay_pred got p=%b addr=%h want 0/100", bus.p, bus.addr); end
    bus.go = 1'b1;
    step();
    tests++; if (bus.imem_addr !== 12'h014) begin fails++; $display("FAIL decay_next got %h want 014", bus.imem_addr); end
    // one taken hit: ctr 0 -> 1 (still not taken), target replaced
    bus.go = 1'b0;
    update(12'h010, 1'b1, 12'h180);
    jump(12'h010);
    tests++; if (bus.p !== 1'b0 || bus.addr !== 12'h180) begin fails++; $display("FAIL retrain1 got p=%b addr=%h want 0/180", bus.p, bus.addr); end
    update(12'h010, 1'b1, 12'h180);
    tests++; if (bus.p !== 1'b1 || bus.addr !== 12'h180) begin fails++; $display("FAIL retrain2 got p=%b addr=%h want 1/180", bus.p, bus.addr); end
    $display("[TB] decay: p=%b addr=%h", bus.p, bus.addr);
  endtask

  task automatic test_overwrite();
    // 0x050 shares index 4 with 0x010; a not-taken miss must not disturb it
    update(12'h050, 1'b0, 12'h3C0);
    jump(12'h010);
    tests++; if (bus.p !== 1'b1 || bus.addr !== 12'h180) begin fails++; $display("FAIL nt_miss got p=%b addr=%h want 1/180", bus.p, bus.addr); end
    // 0x030 also maps to index 4: taken miss evicts 0x010
    update(12'h030, 1'b1, 12'h3C3);
    tests++; if (bus.p !== 1'b0 || bus.addr !== 12'h000) begin fails++; $display("FAIL evict_old got p=%b addr=%h want 0/000", bus.p, bus.addr); end
    jump(12'h030);
    tests++; if (bus.p !== 1'b1 || bus.addr !== 12'h3C0) begin fails++; $display("FAIL evict_new got p=%b addr=%h want 1/3c0", bus.p, bus.addr); end
    $display("[TB] overwrite: p=%b addr=%h", bus.p, bus.addr);
  endtask

  task automatic test_hold_redirect();
    jump(12'h020);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (bus.imem_addr !== 12'h020) begin fails++; $display("FAIL hold%0d got %h want 020", i, bus.imem_addr); end
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 12'h203;  // low bits are discarded
    step();
    bus.redirect = 1'b0;
    tests++; if (bus.imem_addr !== 12'h200) begin fails++; $display("FAIL redirect_stall got %h want 200", bus.imem_addr); end
    $display("[TB] hold/redirect: pc=%h", bus.imem_addr);
  endtask

  task automatic test_wrap();
    jump(12'hFFC);
    tests++; if (bus.pc_4 !== 12'h000 || bus.p !== 1'b0) begin fails++; $display("FAIL wrap_pc4 got %h p=%b want 000/0", bus.pc_4, bus.p); end
    bus.go = 1'b1;
    step();
    tests++; if (bus.imem_addr !== 12'h000) begin fails++; $display("FAIL wrap_next got %h want 000", bus.imem_addr); end
    $display("[TB] wrap: pc=%h", bus.imem_addr);
  endtask

  task automatic test_collision();
    jump(12'h040);
    bus.upd_valid = 1'b1;
    bus.upd_pc = 12'h040;
    bus.upd_taken = 1'b1;
    bus.upd_target = 12'h300;
    #1;
    tests++; if (bus.p !== 1'b0 || bus.addr !== 12'h000) begin fails++; $display("FAIL coll_old got p=%b addr=%h want 0/000", bus.p, bus.addr); end
    step();
    bus.upd_valid = 1'b0;
    tests++; if (bus.p !== 1'b1 || bus.addr !== 12'h300) begin fails++; $display("FAIL coll_new got p=%b addr=%h want 1/300", bus.p, bus.addr); end
    bus.go = 1'b1;
    step();
    tests++; if (bus.imem_addr !== 12'h300) begin fails++; $display("FAIL coll_follow got %h want 300", bus.imem_addr); end
    $display("[TB] collision: pc=%h", bus.imem_addr);
  endtask

  task automatic test_async_reset();
    bus.go = 1'b1;
    step();  // PC now 0x304
    #2;
    rst = 1'b1;
    #1;
    tests++; if (bus.imem_addr !== 12'h000 || bus.p !== 1'b0) begin fails++; $display("FAIL async_rst got pc=%h p=%b want 000/0", bus.imem_addr, bus.p); end
    @(negedge clk);
    rst = 1'b0;
    // BTB cleared: 0x040 entry gone, so fetch proceeds sequentially
    step();
    tests++; if (bus.imem_addr !== 12'h004) begin fails++; $display("FAIL post_rst got %h want 004", bus.imem_addr); end
    $display("[TB] async reset: pc=%h", bus.imem_addr);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_btb_alloc();
    test_counter_decay();
    test_overwrite();
    test_hold_redirect();
    test_wrap();
    test_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that owns the program counter and a direct-mapped branch target buffer (BTB). It drives the instruction-memory address and produces the four values latched by the IF/ID pipeline register: `pc_4`, `instruction`, predicted target `addr`, and prediction bit `p`. Execute-stage branch resolution feeds back into the block as a BTB update and, on misprediction, a PC redirect.

## Interface
Parameters:
- `PC_W`, 12: PC and target width in bits; byte address, word-aligned.
- `BTB_N`, 8: number of BTB entries; power of two, at least 2.
- `RESET_PC`, 12'h000: PC value after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `go`  in  1  advance enable, the AND of downstream stall-free conditions. When 0, the PC holds.
- `redirect`  in  1  misprediction flush from execute.
- `redirect_pc`  in  PC_W  correct next PC.
- `upd_valid`  in  1  a resolved branch is reported this cycle.
- `upd_pc`  in  PC_W  PC of the resolved branch.
- `upd_taken`  in  1  actual branch outcome.
- `upd_target`  in  PC_W  actual taken target.
- `imem_addr`  out  PC_W  current PC, driven to the asynchronous instruction ROM.
- `imem_data`  in  32  instruction word returned combinationally.
- `pc_4`  out  PC_W  PC + 4, modulo 2^PC_W.
- `instruction`  out  32  equals `imem_data`.
- `addr`  out  PC_W  predicted target. 0 when there is no BTB hit.
- `p`  out  1  predicted taken.

## Operation
- The PC register holds the fetch address. `imem_addr` = PC.
- BTB indexing:
  - index = PC[log2(BTB_N)+1:2]
  - tag = PC[PC_W-1:log2(BTB_N)+2]
- Each BTB entry holds: `valid`, `tag`, `target`, and a 2-bit saturating counter `ctr`.
- Lookup is combinational:
  - hit = valid && tag match.
  - p = hit && ctr[1].
  - addr = hit ? target : 0.
- Next-PC priority:
  1. `redirect` → `redirect_pc`. This applies even when `go`=0.
  2. `!go` → PC (hold).
  3. `p` → `addr`.
  4. otherwise → PC+4.
- BTB update, applied when `upd_valid` is asserted. The entry is selected by `upd_pc`; the update is independent of `go`.
  - Hit, taken: ctr increments, saturating at 3; target ← `upd_target`.
  - Hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate the entry, overwriting any occupant. valid=1, tag written, target ← `upd_target`, ctr=2.
  - Miss, not taken: no change.
- Reset: PC=RESET_PC; every entry has valid=0 and ctr=1.
  - Resulting outputs: `imem_addr`=RESET_PC, `pc_4`=RESET_PC+4, `p`=0, `addr`=0.
- Arithmetic: PC+4 wraps, so 12'hFFC → 12'h000. `redirect_pc`, `upd_target` and `RESET_PC` have bits [1:0] ignored and forced to 0.

## Timing
- Output latency: 0 cycles. All outputs are combinational from the PC and BTB state.
- PC latency: 1 cycle. Next PC appears after the next rising edge.
- `redirect` in cycle n → `imem_addr`=`redirect_pc` in cycle n+1, whatever the state of `go`.
- Update/lookup collision: a same-cycle update and lookup on the same index uses the pre-update entry. The write is visible from the next cycle.
- `rst` asserted mid-operation clears the state immediately, asynchronously. The first edge after deassertion fetches from RESET_PC+4, or from the predicted target if a BTB hit exists.

## Structure
- Shared package `fetch_pkg` holds:
  - `PC_W`
  - BTB index/tag width functions
  - typedef `btb_entry_t` {valid, tag, target, ctr}
  - counter constants `CTR_SNT`=0, `CTR_WNT`=1, `CTR_WT`=2, `CTR_ST`=3
- One sub-module, `btb`: entry array, combinational lookup port, registered update port, async reset.
- `fetch_stage` contains the PC register, the next-PC mux and the PC+4 adder, and instantiates `btb`.

## Test plan
- Reset, then `go`=1 with no updates → `imem_addr` sequence 0x000, 0x004, 0x008; `p`=0 and `addr`=0 throughout.
- Update 0x010 taken → 0x100; later fetch 0x010 → `p`=1, `addr`=0x100, next `imem_addr`=0x100.
- Three not-taken updates on 0x010 after allocation → ctr goes 2→1→0→0; fetch 0x010 gives `p`=0 and next PC 0x014.
- `go`=0 for 3 cycles at PC 0x020 → PC holds 0x020. Assert `redirect`=1, `redirect_pc`=0x200 with `go`=0 → next PC is 0x200.
- PC at 0xFFC with no hit → `pc_4`=0x000, and the next PC is 0x000.
- Update and lookup on the same index in the same cycle → that cycle's `p` reflects the old entry, and the next fetch of that PC reflects the new entry. Assert `rst` mid-run → PC=0x000 and `p`=0 within the same cycle.
